// File: rtl/expr_result_misr.sv
// Capture stage for the packed expression result bus: folds each accepted
// vector into a MISR signature and compares it with an expected value at the end of a run.
module expr_result_misr #(
  parameter int unsigned           Y_W   = 90,
  parameter int unsigned           SIG_W = 32,
  parameter logic [SIG_W-1:0]      POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]      SEED  = 32'hFFFFFFFF,
  parameter int unsigned           CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  input  logic [SIG_W-1:0] exp_sig,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int unsigned NCHUNK = (Y_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          num_lat;
  logic [NCHUNK*SIG_W-1:0]   y_pad;
  logic [SIG_W-1:0]          fold;
  logic [SIG_W-1:0]          sig_next;

  // Top chunk is zero-extended by padding in_y up to a whole number of chunks.
  always_comb begin
    y_pad = '0;
    y_pad[Y_W-1:0] = in_y;
    fold = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      fold = fold ^ y_pad[i*SIG_W +: SIG_W];
    end
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sig      <= '0;
      vec_cnt  <= '0;
      num_lat  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sig      <= SEED;
            vec_cnt  <= '0;
            num_lat  <= num_vec;
            pass     <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            in_ready <= (num_vec != '0);
            state    <= (num_vec == '0) ? S_CHECK : S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid && in_ready) begin
            sig     <= sig_next;
            vec_cnt <= vec_cnt + CNT_W'(1);
            if (vec_cnt == num_lat - CNT_W'(1)) begin
              in_ready <= 1'b0;
              state    <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          pass  <= (sig == exp_sig);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
